// File: rtl/aes_sbox_sched.sv
// Shares LANES external AES S-box lanes between SubBytes (128-bit) and SubWord (32-bit) jobs.
// One job in flight; result held until the output handshake; inputs stall outside IDLE.
module aes_sbox_sched #(
  parameter int LANES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 st_in_valid,
  output logic                 st_in_ready,
  input  logic [127:0]         st_in_data,
  output logic                 st_out_valid,
  input  logic                 st_out_ready,
  output logic [127:0]         st_out_data,
  input  logic                 kw_in_valid,
  output logic                 kw_in_ready,
  input  logic [31:0]          kw_in_data,
  output logic                 kw_out_valid,
  input  logic                 kw_out_ready,
  output logic [31:0]          kw_out_data,
  output logic [8*LANES-1:0]   sbox_idx,
  input  logic [8*LANES-1:0]   sbox_val,
  output logic                 busy
);

  localparam int NS = 16 / LANES;
  localparam int NK = 4 / LANES;
  localparam int BW = 8 * LANES;
  localparam int CW = $clog2(NS);

  if (!(LANES == 1 || LANES == 2 || LANES == 4)) begin : g_lanes_check
    $error("aes_sbox_sched: LANES must be 1, 2 or 4");
  end

  typedef enum logic [2:0] {IDLE, RUN_S, RUN_K, OUT_S, OUT_K} state_t;

  state_t                   state, state_nx;
  logic [NS-1:0][BW-1:0]    work, res;
  logic [127:0]             res_flat;
  logic [CW-1:0]            cnt;
  logic                     last_k;
  logic                     grant_s, grant_k;

  assign res_flat = res;
  assign busy     = (state != IDLE);

  // Round-robin on contention: the requester not served last time wins a tie.
  assign grant_s = st_in_valid & (~kw_in_valid | last_k);
  assign grant_k = kw_in_valid & (~st_in_valid | ~last_k);

  always_comb begin
    state_nx     = state;
    st_in_ready  = 1'b0;
    kw_in_ready  = 1'b0;
    sbox_idx     = '0;
    st_out_valid = 1'b0;
    kw_out_valid = 1'b0;
    st_out_data  = '0;
    kw_out_data  = '0;
    case (state)
      IDLE: begin
        st_in_ready = grant_s;
        kw_in_ready = grant_k;
        if (grant_s)      state_nx = RUN_S;
        else if (grant_k) state_nx = RUN_K;
      end
      RUN_S: begin
        sbox_idx = work[cnt];
        if (cnt == CW'(NS - 1)) state_nx = OUT_S;
      end
      RUN_K: begin
        sbox_idx = work[cnt];
        if (cnt == CW'(NK - 1)) state_nx = OUT_K;
      end
      OUT_S: begin
        st_out_valid = 1'b1;
        st_out_data  = res_flat;
        if (st_out_ready) state_nx = IDLE;
      end
      OUT_K: begin
        kw_out_valid = 1'b1;
        kw_out_data  = res_flat[31:0];
        if (kw_out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      last_k <= 1'b0;
      work   <= '0;
      res    <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (grant_s) begin
            work   <= st_in_data;
            res    <= '0;
            cnt    <= '0;
            last_k <= 1'b0;
          end else if (grant_k) begin
            work   <= {96'b0, kw_in_data};
            res    <= '0;
            cnt    <= '0;
            last_k <= 1'b1;
          end
        end
        RUN_S, RUN_K: begin
          res[cnt] <= sbox_val;
          cnt      <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_sbox_sched.sv
// Directed bench for aes_sbox_sched: LANES=4 main instance plus LANES=1 and LANES=2 latency builds.
module tb_aes_sbox_sched;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  logic clk, rst_n;
  logic [127:0] st_d;
  logic [31:0]  kw_d;

  logic st_v, st_r, st_ov, st_or, kw_v, kw_r, kw_ov, kw_or, busy4;
  logic [127:0] st_od;
  logic [31:0]  kw_od, idx4, val4;

  logic st_v1, st_r1, st_ov1, kw_v1, kw_r1, kw_ov1, busy1;
  logic [127:0] st_od1;
  logic [31:0]  kw_od1;
  logic [7:0]   idx1, val1;

  logic st_v2, st_r2, st_ov2, kw_v2, kw_r2, kw_ov2, busy2;
  logic [127:0] st_od2;
  logic [31:0]  kw_od2;
  logic [15:0]  idx2, val2;

  int vectors = 0;
  int miscompares = 0;

  aes_sbox_sched #(.LANES(4)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .st_in_valid(st_v), .st_in_ready(st_r), .st_in_data(st_d),
    .st_out_valid(st_ov), .st_out_ready(st_or), .st_out_data(st_od),
    .kw_in_valid(kw_v), .kw_in_ready(kw_r), .kw_in_data(kw_d),
    .kw_out_valid(kw_ov), .kw_out_ready(kw_or), .kw_out_data(kw_od),
    .sbox_idx(idx4), .sbox_val(val4), .busy(busy4));

  aes_sbox_sched #(.LANES(1)) u_l1 (
    .clk(clk), .rst_n(rst_n),
    .st_in_valid(st_v1), .st_in_ready(st_r1), .st_in_data(st_d),
    .st_out_valid(st_ov1), .st_out_ready(1'b1), .st_out_data(st_od1),
    .kw_in_valid(kw_v1), .kw_in_ready(kw_r1), .kw_in_data(kw_d),
    .kw_out_valid(kw_ov1), .kw_out_ready(1'b1), .kw_out_data(kw_od1),
    .sbox_idx(idx1), .sbox_val(val1), .busy(busy1));

  aes_sbox_sched #(.LANES(2)) u_l2 (
    .clk(clk), .rst_n(rst_n),
    .st_in_valid(st_v2), .st_in_ready(st_r2), .st_in_data(st_d),
    .st_out_valid(st_ov2), .st_out_ready(1'b1), .st_out_data(st_od2),
    .kw_in_valid(kw_v2), .kw_in_ready(kw_r2), .kw_in_data(kw_d),
    .kw_out_valid(kw_ov2), .kw_out_ready(1'b1), .kw_out_data(kw_od2),
    .sbox_idx(idx2), .sbox_val(val2), .busy(busy2));

  // Combinational S-box lanes returning in the same cycle.
  always_comb begin
    val4 = '0;
    for (int l = 0; l < 4; l++) val4[8*l +: 8] = SBOX[idx4[8*l +: 8]];
    val2 = '0;
    for (int l = 0; l < 2; l++) val2[8*l +: 8] = SBOX[idx2[8*l +: 8]];
    val1 = SBOX[idx1];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic sub_ov(input int inst, input bit key);
    if (inst == 1) return key ? kw_ov1 : st_ov1;
    return key ? kw_ov2 : st_ov2;
  endfunction

  function automatic logic sub_rdy(input int inst, input bit key);
    if (inst == 1) return key ? kw_r1 : st_r1;
    return key ? kw_r2 : st_r2;
  endfunction

  function automatic logic [127:0] sub_od(input int inst, input bit key);
    if (inst == 1) return key ? {96'b0, kw_od1} : st_od1;
    return key ? {96'b0, kw_od2} : st_od2;
  endfunction

  task automatic set_v(input int inst, input bit key, input logic v);
    if (inst == 1) begin
      if (key) kw_v1 = v; else st_v1 = v;
    end else begin
      if (key) kw_v2 = v; else st_v2 = v;
    end
  endtask

  // Returns cycles from accept to valid, counting the accept cycle.
  task automatic sub_job(input int inst, input bit key, output int lat, output logic [127:0] dat);
    int k;
    set_v(inst, key, 1'b1);
    #1;
    chk($sformatf("l%0d_%s_ready", inst, key ? "kw" : "st"), 128'(sub_rdy(inst, key)), 128'(1'b1));
    @(negedge clk);
    set_v(inst, key, 1'b0);
    k = 0;
    while (!sub_ov(inst, key) && k < 40) begin
      @(negedge clk);
      k++;
    end
    lat = k + 1;
    dat = sub_od(inst, key);
    @(negedge clk);
  endtask

  logic [127:0] vec, vec_exp, exp0, exp_tie, exp01, d;
  int lat;

  initial begin
    vec     = 128'h00112233445566778899aabbccddeeff;
    vec_exp = 128'h638293c31bfc33f5c4eeacea4bc12816;
    exp0    = {16{8'h63}};
    exp_tie = {{15{8'h63}}, 8'hed};
    exp01   = {{15{8'h63}}, 8'h7c};

    rst_n = 1'b0;
    st_v = 0; kw_v = 0; st_or = 1; kw_or = 1; st_d = '0; kw_d = '0;
    st_v1 = 0; kw_v1 = 0; st_v2 = 0; kw_v2 = 0;
    repeat (2) @(negedge clk);
    chk("rst_st_ov", 128'(st_ov), 128'(1'b0));
    chk("rst_kw_ov", 128'(kw_ov), 128'(1'b0));
    chk("rst_busy", 128'(busy4), 128'(1'b0));
    chk("rst_st_od", st_od, 128'h0);
    chk("rst_idx", 128'(idx4), 128'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // State job of all zeros, LANES=4.
    st_d = 128'h0; st_v = 1'b1;
    #1 chk("t1_st_ready", 128'(st_r), 128'(1'b1));
    @(negedge clk);
    st_v = 1'b0;
    chk("t1_busy_run", 128'(busy4), 128'(1'b1));
    chk("t1_st_ready_run", 128'(st_r), 128'(1'b0));
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk("t1_early_valid", 128'(st_ov), 128'(1'b0));
      chk("t1_busy", 128'(busy4), 128'(1'b1));
    end
    @(negedge clk);
    chk("t1_valid", 128'(st_ov), 128'(1'b1));
    chk("t1_data", st_od, exp0);
    @(negedge clk);
    chk("t1_idle", 128'(busy4), 128'(1'b0));

    // Key job.
    kw_d = 32'h09cf4f3c; kw_v = 1'b1;
    #1 chk("t2_kw_ready", 128'(kw_r), 128'(1'b1));
    @(negedge clk);
    kw_v = 1'b0;
    chk("t2_idx", 128'(idx4), 128'h09cf4f3c);
    chk("t2_early_valid", 128'(kw_ov), 128'(1'b0));
    @(negedge clk);
    chk("t2_valid", 128'(kw_ov), 128'(1'b1));
    chk("t2_data", 128'(kw_od), 128'h018a84eb);
    @(negedge clk);

    // Tie from reset, then backpressure on the state output.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    st_d = 128'h53; kw_d = 32'hff; st_v = 1'b1; kw_v = 1'b1;
    #1;
    chk("t3_kw_first", 128'(kw_r), 128'(1'b1));
    chk("t3_st_wait", 128'(st_r), 128'(1'b0));
    @(negedge clk);
    chk("t3_run_kw_r", 128'(kw_r), 128'(1'b0));
    chk("t3_run_st_r", 128'(st_r), 128'(1'b0));
    @(negedge clk);
    chk("t3_kw_valid", 128'(kw_ov), 128'(1'b1));
    chk("t3_kw_data", 128'(kw_od), 128'h63636316);
    @(negedge clk);
    chk("t3_st_second", 128'(st_r), 128'(1'b1));
    chk("t3_kw_blocked", 128'(kw_r), 128'(1'b0));
    st_or = 1'b0;
    @(negedge clk);
    st_v = 1'b0;
    chk("t3_idx", 128'(idx4), 128'h53);
    repeat (4) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      chk("t4_hold_valid", 128'(st_ov), 128'(1'b1));
      chk("t4_hold_data", st_od, exp_tie);
      chk("t4_kw_ready_low", 128'(kw_r), 128'(1'b0));
      @(negedge clk);
    end
    st_or = 1'b1;
    @(negedge clk);
    chk("t4_idle", 128'(busy4), 128'(1'b0));
    chk("t4_st_ov_low", 128'(st_ov), 128'(1'b0));
    chk("t4_kw_accept", 128'(kw_r), 128'(1'b1));
    @(negedge clk);
    kw_v = 1'b0;
    @(negedge clk);
    chk("t4_kw_valid", 128'(kw_ov), 128'(1'b1));
    chk("t4_kw_data", 128'(kw_od), 128'h63636316);
    @(negedge clk);

    // Reset on the second RUN_S beat.
    st_d = vec; st_v = 1'b1;
    #1 chk("t5_st_ready", 128'(st_r), 128'(1'b1));
    @(negedge clk);
    st_v = 1'b0;
    chk("t5_idx_beat0", 128'(idx4), 128'hccddeeff);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t5_st_ov", 128'(st_ov), 128'(1'b0));
    chk("t5_st_od", st_od, 128'h0);
    chk("t5_kw_ov", 128'(kw_ov), 128'(1'b0));
    chk("t5_kw_od", 128'(kw_od), 128'h0);
    chk("t5_busy", 128'(busy4), 128'(1'b0));
    chk("t5_idx", 128'(idx4), 128'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t5_no_partial", 128'(st_ov), 128'(1'b0));
    end
    st_d = 128'h01; st_v = 1'b1;
    #1 chk("t5_fresh_ready", 128'(st_r), 128'(1'b1));
    @(negedge clk);
    st_v = 1'b0;
    repeat (3) @(negedge clk);
    @(negedge clk);
    chk("t5_fresh_valid", 128'(st_ov), 128'(1'b1));
    chk("t5_fresh_data", st_od, exp01);
    @(negedge clk);

    // LANES=1 and LANES=2 builds.
    st_d = vec; kw_d = 32'h09cf4f3c;
    sub_job(1, 1'b0, lat, d);
    chk("l1_st_latency", 128'(lat), 128'd17);
    chk("l1_st_data", d, vec_exp);
    sub_job(2, 1'b0, lat, d);
    chk("l2_st_latency", 128'(lat), 128'd9);
    chk("l2_st_data", d, vec_exp);
    sub_job(1, 1'b1, lat, d);
    chk("l1_kw_latency", 128'(lat), 128'd5);
    chk("l1_kw_data", d, 128'h018a84eb);
    sub_job(2, 1'b1, lat, d);
    chk("l2_kw_latency", 128'(lat), 128'd3);
    chk("l2_kw_data", d, 128'h018a84eb);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
